// File: rtl/acc_num_gen.sv
// acc_num_gen: accumulation framing (new_acc/dump) and completed-accumulation counter; define ACC_NUM_GEN_SYNC_ERR_EN to restart on misaligned sync_in
module acc_num_gen #(
    parameter int VEC_LEN_BITS = 11
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        arm,
    input  logic        sync_in,
    input  logic        valid_in,
    input  logic [31:0] acc_len,
    output logic        new_acc,
    output logic        dump,
    output logic [31:0] acc_num,
    output logic        armed,
    output logic        sync_err
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
    state_t state, state_n;
    logic arm_d, arm_rise, restart, start, active, hit, first, last, wrap;
    logic new_acc_n, dump_n, armed_n, sync_err_n;
    logic [VEC_LEN_BITS-1:0] samp, samp_n, cs;
    logic [31:0] spec, spec_n, cp, len_q, len_n, acc_num_n;

    assign arm_rise = arm & ~arm_d;
`ifdef ACC_NUM_GEN_SYNC_ERR_EN
    assign restart = state == RUN && sync_in && (samp != '0 || spec != '0);
`else
    assign restart = 1'b0;
`endif

    // state register
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) state <= IDLE;
        else state <= state_n;
    end

    // next state: an arm edge re-arms from anywhere, sync_in starts the run
    always_comb begin
        state_n = arm_rise ? ARMED : (state == ARMED && sync_in) ? RUN : state;
    end

    // counters and pulses; a start (first sync or misaligned resync) treats the current sample as sample 0
    always_comb begin
        start      = (state == ARMED && sync_in) || restart;
        active     = state == RUN || start;
        cs         = start ? '0 : samp;
        cp         = start ? '0 : spec;
        hit        = active && valid_in && !arm_rise;
        first      = hit && cs == '0 && cp == '0;
        len_n      = (start || first) ? (acc_len == '0 ? 32'd1 : acc_len) : len_q;
        wrap       = hit && &cs;
        last       = wrap && cp == len_n - 32'd1;
        samp_n     = arm_rise ? '0 : hit ? cs + VEC_LEN_BITS'(1) : cs;
        spec_n     = arm_rise ? '0 : wrap ? (last ? '0 : cp + 32'd1) : cp;
        acc_num_n  = arm_rise ? '0 : last ? acc_num + 32'd1 : acc_num;
        sync_err_n = !arm_rise && (sync_err || restart);
        new_acc_n  = first;
        dump_n     = last;
        armed_n    = state_n == ARMED;
    end

    // registered datapath and outputs
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            arm_d    <= 1'b0;
            samp     <= '0;
            spec     <= '0;
            len_q    <= 32'd1;
            acc_num  <= '0;
            new_acc  <= 1'b0;
            dump     <= 1'b0;
            armed    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            arm_d    <= arm;
            samp     <= samp_n;
            spec     <= spec_n;
            len_q    <= len_n;
            acc_num  <= acc_num_n;
            new_acc  <= new_acc_n;
            dump     <= dump_n;
            armed    <= armed_n;
            sync_err <= sync_err_n;
        end
    end
endmodule

// File: tb/tb_acc_num_gen.sv
// tb_acc_num_gen: directed checks of acc_num_gen with 4 samples per spectrum
module tb_acc_num_gen;
    localparam int VB = 2;
    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        arm = 1'b0, sync_in = 1'b0, valid_in = 1'b0;
    logic [31:0] acc_len = 32'd1;
    logic        new_acc, dump, armed, sync_err;
    logic [31:0] acc_num;
    int n_chk = 0, n_fail = 0;

    acc_num_gen #(.VEC_LEN_BITS(VB)) dut (
        .user_clk(user_clk), .user_rst(user_rst), .arm(arm), .sync_in(sync_in),
        .valid_in(valid_in), .acc_len(acc_len), .new_acc(new_acc), .dump(dump),
        .acc_num(acc_num), .armed(armed), .sync_err(sync_err)
    );

    always #5 user_clk = ~user_clk;

    task automatic cyc(input logic a, input logic s, input logic v);
        arm = a; sync_in = s; valid_in = v;
        @(posedge user_clk); #1;
    endtask

    task automatic do_arm();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge user_clk);
        #1;
        n_chk++; if ({new_acc, dump, armed, sync_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {new_acc, dump, armed, sync_err}); end
        n_chk++; if (acc_num !== 32'd0) begin n_fail++; $display("FAIL reset_acc_num got %0d want 0", acc_num); end
        user_rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b1);
        n_chk++; if ({new_acc, dump, armed} !== 3'b0) begin n_fail++; $display("FAIL idle_ignore got %b want 000", {new_acc, dump, armed}); end
    endtask

    task automatic test_basic();
        acc_len = 32'd3;
        do_arm();
        n_chk++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed got %b want 1", armed); end
        for (int k = 0; k < 24; k++) begin
            cyc(1'b0, k == 0, 1'b1);
            n_chk++; if (new_acc !== (k % 12 == 0)) begin n_fail++; $display("FAIL basic_new_acc k=%0d got %b want %b", k, new_acc, k % 12 == 0); end
            n_chk++; if (dump !== (k % 12 == 11)) begin n_fail++; $display("FAIL basic_dump k=%0d got %b want %b", k, dump, k % 12 == 11); end
            n_chk++; if (acc_num !== 32'((k + 1) / 12)) begin n_fail++; $display("FAIL basic_acc_num k=%0d got %0d want %0d", k, acc_num, (k + 1) / 12); end
        end
        n_chk++; if (armed !== 1'b0) begin n_fail++; $display("FAIL basic_run_armed got %b want 0", armed); end
    endtask

    task automatic test_len0();
        acc_len = 32'd0;
        do_arm();
        n_chk++; if (acc_num !== 32'd0) begin n_fail++; $display("FAIL len0_cleared got %0d want 0", acc_num); end
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, k == 0, 1'b1);
            n_chk++; if (dump !== (k % 4 == 3)) begin n_fail++; $display("FAIL len0_dump k=%0d got %b want %b", k, dump, k % 4 == 3); end
            n_chk++; if (new_acc !== (k % 4 == 0)) begin n_fail++; $display("FAIL len0_new_acc k=%0d got %b want %b", k, new_acc, k % 4 == 0); end
        end
        n_chk++; if (acc_num !== 32'd5) begin n_fail++; $display("FAIL len0_acc_num got %0d want 5", acc_num); end
    endtask

    task automatic test_toggle();
        acc_len = 32'd2;
        do_arm();
        for (int j = 0; j < 16; j++) begin
            cyc(1'b0, j == 0, j % 2 == 0);
            n_chk++; if (dump !== (j == 14)) begin n_fail++; $display("FAIL toggle_dump j=%0d got %b want %b", j, dump, j == 14); end
            n_chk++; if (new_acc !== (j == 0)) begin n_fail++; $display("FAIL toggle_new_acc j=%0d got %b want %b", j, new_acc, j == 0); end
        end
        n_chk++; if (acc_num !== 32'd1) begin n_fail++; $display("FAIL toggle_acc_num got %0d want 1", acc_num); end
    endtask

    task automatic test_sync_err();
        logic se, exp_dump, exp_new;
        acc_len = 32'd2;
        do_arm();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, k == 0 || k == 6, 1'b1);
`ifdef ACC_NUM_GEN_SYNC_ERR_EN
            se = k >= 6; exp_dump = 1'b0; exp_new = k == 0 || k == 6;
`else
            se = 1'b0; exp_dump = k == 7; exp_new = k == 0;
`endif
            n_chk++; if (sync_err !== se) begin n_fail++; $display("FAIL sync_err_flag k=%0d got %b want %b", k, sync_err, se); end
            n_chk++; if (dump !== exp_dump) begin n_fail++; $display("FAIL sync_err_dump k=%0d got %b want %b", k, dump, exp_dump); end
            n_chk++; if (new_acc !== exp_new) begin n_fail++; $display("FAIL sync_err_new_acc k=%0d got %b want %b", k, new_acc, exp_new); end
            n_chk++; if (acc_num !== 32'(exp_dump ? 1 : 0) && k < 7) begin n_fail++; $display("FAIL sync_err_acc_num k=%0d got %0d want 0", k, acc_num); end
        end
    endtask

    task automatic test_reset_mid();
        acc_len = 32'd4;
        do_arm();
        n_chk++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rearm_sync_err got %b want 0", sync_err); end
        for (int k = 0; k < 53; k++) cyc(1'b0, k == 0, 1'b1);
        n_chk++; if (acc_num !== 32'd3) begin n_fail++; $display("FAIL mid_pre_acc_num got %0d want 3", acc_num); end
        user_rst = 1'b1;
        #1;
        n_chk++; if (acc_num !== 32'd0) begin n_fail++; $display("FAIL mid_async_acc_num got %0d want 0", acc_num); end
        n_chk++; if ({new_acc, dump, armed} !== 3'b0) begin n_fail++; $display("FAIL mid_async_flags got %b want 000", {new_acc, dump, armed}); end
        #2 user_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, k % 4 == 0, 1'b1);
            n_chk++; if ({new_acc, dump, armed} !== 3'b0 || acc_num !== 32'd0) begin n_fail++; $display("FAIL noarm k=%0d got %b/%0d want 000/0", k, {new_acc, dump, armed}, acc_num); end
        end
    endtask

    task automatic test_wrap();
        acc_len = 32'd1;
        do_arm();
        force dut.acc_num = 32'hFFFF_FFFF;
        cyc(1'b0, 1'b0, 1'b0);
        release dut.acc_num;
        n_chk++; if (acc_num !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffffffff", acc_num); end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, k == 0, 1'b1);
            n_chk++; if (dump !== (k == 3)) begin n_fail++; $display("FAIL wrap_dump k=%0d got %b want %b", k, dump, k == 3); end
        end
        n_chk++; if (acc_num !== 32'd0) begin n_fail++; $display("FAIL wrap_acc_num got %h want 00000000", acc_num); end
    endtask

    task automatic test_arm_priority();
        acc_len = 32'd1;
        do_arm();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            n_chk++; if ({new_acc, dump, armed} !== 3'b001) begin n_fail++; $display("FAIL armed_ignore k=%0d got %b want 001", k, {new_acc, dump, armed}); end
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, k == 0, 1'b1);
        n_chk++; if (acc_num !== 32'd1) begin n_fail++; $display("FAIL prio_pre got %0d want 1", acc_num); end
        for (int k = 4; k < 8; k++) begin
            cyc(k == 7, 1'b0, 1'b1);
            n_chk++; if (dump !== 1'b0) begin n_fail++; $display("FAIL prio_dump k=%0d got %b want 0", k, dump); end
            n_chk++; if (new_acc !== (k == 4)) begin n_fail++; $display("FAIL prio_new_acc k=%0d got %b want %b", k, new_acc, k == 4); end
        end
        n_chk++; if (acc_num !== 32'd0 || armed !== 1'b1) begin n_fail++; $display("FAIL prio_result got %0d/%b want 0/1", acc_num, armed); end
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_toggle();
        test_sync_err();
        test_reset_mid();
        test_wrap();
        test_arm_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
